ex_result_stage: RTL and testbench

- Registered execute-to-memory stage directly downstream of the ALU.
- Captures the ALU result and its zero/minus flags together with destination-register and branch metadata.
- Resolves conditional branches from the flags and presents the result to the memory/writeback stage through a valid/ready handshake.
- Uses a two-entry skid buffer, so the upstream ready path is registered and full throughput is kept under backpressure.

---
 rtl/ex_result_stage.sv | 124 ++++++++++++
 tb/tb_ex_result_stage.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/ex_result_stage.sv
// rtl/ex_result_stage.sv - execute-to-memory result stage with two-entry skid buffer
// Captures ALU result/flags with branch metadata, resolves taken, and hands off via valid/ready.
module ex_result_stage #(
  parameter int DATA_W = 32,
  parameter int RD_W   = 5,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] alu_out,
  input  logic              alu_zero,
  input  logic              alu_minus,
  input  logic [RD_W-1:0]   in_rd,
  input  logic              in_reg_write,
  input  logic [2:0]        in_br_type,
  input  logic [DATA_W-1:0] in_br_target,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_result,
  output logic              out_zero,
  output logic              out_minus,
  output logic [RD_W-1:0]   out_rd,
  output logic              out_reg_write,
  output logic              out_taken,
  output logic [DATA_W-1:0] out_target,
  output logic [CNT_W-1:0]  taken_count
);

  typedef struct packed {
    logic [DATA_W-1:0] result;
    logic              zero;
    logic              minus;
    logic [RD_W-1:0]   rd;
    logic              reg_write;
    logic              taken;
    logic [DATA_W-1:0] target;
  } entry_t;

  entry_t           main_q;
  entry_t           skid_q;
  entry_t           in_entry;
  logic             main_valid;
  logic             skid_valid;
  logic             taken_in;
  logic             accept;
  logic             deliver;
  logic [CNT_W-1:0] count_q;

  // Branch condition is resolved once, at capture, from the incoming flags.
  always_comb begin
    taken_in = 1'b0;
    case (in_br_type)
      3'b001:  taken_in = alu_zero;
      3'b010:  taken_in = !alu_zero;
      3'b011:  taken_in = alu_minus;
      3'b100:  taken_in = !alu_minus;
      default: taken_in = 1'b0;
    endcase
  end

  always_comb begin
    in_entry           = '0;
    in_entry.result    = alu_out;
    in_entry.zero      = alu_zero;
    in_entry.minus     = alu_minus;
    in_entry.rd        = in_rd;
    in_entry.reg_write = in_reg_write;
    in_entry.taken     = taken_in;
    in_entry.target    = in_br_target;
  end

  // Ready depends only on skid occupancy, so there is no path from out_ready.
  assign in_ready = !skid_valid;
  assign accept   = in_valid && in_ready;
  assign deliver  = main_valid && out_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      main_q     <= '0;
      skid_q     <= '0;
      main_valid <= 1'b0;
      skid_valid <= 1'b0;
      count_q    <= '0;
    end else begin
      // A deliver in a flush cycle still reaches downstream, so it is counted.
      if (deliver && main_q.taken)
        count_q <= count_q + 1'b1;

      if (flush) begin
        main_valid <= 1'b0;
        skid_valid <= 1'b0;
      end else if (!main_valid || deliver) begin
        if (skid_valid) begin
          main_q     <= skid_q;
          main_valid <= 1'b1;
          if (accept)
            skid_q <= in_entry;
          skid_valid <= accept;
        end else begin
          if (accept)
            main_q <= in_entry;
          main_valid <= accept;
        end
      end else if (accept) begin
        skid_q     <= in_entry;
        skid_valid <= 1'b1;
      end
    end
  end

  assign out_valid     = main_valid;
  assign out_result    = main_q.result;
  assign out_zero      = main_q.zero;
  assign out_minus     = main_q.minus;
  assign out_rd        = main_q.rd;
  assign out_reg_write = main_q.reg_write;
  assign out_taken     = main_q.taken;
  assign out_target    = main_q.target;
  assign taken_count   = count_q;

endmodule

// File: tb/tb_ex_result_stage.sv
// tb/tb_ex_result_stage.sv - self-checking bench for ex_result_stage
// Table-driven single-entry vectors plus hand sequences for skid, flush, wrap and reset.
module tb_ex_result_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] alu_out;
  logic        alu_zero;
  logic        alu_minus;
  logic [4:0]  in_rd;
  logic        in_reg_write;
  logic [2:0]  in_br_type;
  logic [31:0] in_br_target;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_result;
  logic        out_zero;
  logic        out_minus;
  logic [4:0]  out_rd;
  logic        out_reg_write;
  logic        out_taken;
  logic [31:0] out_target;
  logic [15:0] taken_count;

  int checks = 0;
  int failures = 0;
  int exp_cnt = 0;

  ex_result_stage dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .alu_out(alu_out), .alu_zero(alu_zero), .alu_minus(alu_minus),
    .in_rd(in_rd), .in_reg_write(in_reg_write),
    .in_br_type(in_br_type), .in_br_target(in_br_target),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_result(out_result), .out_zero(out_zero), .out_minus(out_minus),
    .out_rd(out_rd), .out_reg_write(out_reg_write),
    .out_taken(out_taken), .out_target(out_target),
    .taken_count(taken_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] alu;
    logic        z;
    logic        m;
    logic [4:0]  rd;
    logic        rw;
    logic [2:0]  bt;
    logic [31:0] tg;
    logic        e_taken;
    logic [15:0] e_cnt;
  } vec_t;

  vec_t vecs[10];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [31:0] a, input logic z, input logic m, input logic [4:0] rd,
                       input logic rw, input logic [2:0] bt, input logic [31:0] tg);
    in_valid     = 1'b1;
    alu_out      = a;
    alu_zero     = z;
    alu_minus    = m;
    in_rd        = rd;
    in_reg_write = rw;
    in_br_type   = bt;
    in_br_target = tg;
  endtask

  task automatic chk_cleared(input string tag);
    chk({tag, "_out_valid"}, 64'(out_valid), 64'd0);
    chk({tag, "_in_ready"}, 64'(in_ready), 64'd1);
    chk({tag, "_result"}, 64'(out_result), 64'd0);
    chk({tag, "_flags"}, 64'({out_zero, out_minus, out_reg_write, out_taken}), 64'd0);
    chk({tag, "_rd"}, 64'(out_rd), 64'd0);
    chk({tag, "_target"}, 64'(out_target), 64'd0);
    chk({tag, "_count"}, 64'(taken_count), 64'd0);
  endtask

  initial begin
    vecs[0] = '{32'h0000_0010, 1'b0, 1'b0, 5'd3,  1'b1, 3'b000, 32'h0000_0000, 1'b0, 16'd0};
    vecs[1] = '{32'h0000_0000, 1'b1, 1'b0, 5'd0,  1'b0, 3'b001, 32'h0000_0100, 1'b1, 16'd1};
    vecs[2] = '{32'h0000_0000, 1'b1, 1'b0, 5'd0,  1'b0, 3'b010, 32'h0000_0100, 1'b0, 16'd1};
    vecs[3] = '{32'h8000_0000, 1'b0, 1'b1, 5'd0,  1'b0, 3'b011, 32'h0000_0100, 1'b1, 16'd2};
    vecs[4] = '{32'hFFFF_FFFF, 1'b0, 1'b1, 5'd0,  1'b0, 3'b100, 32'h0000_0100, 1'b0, 16'd2};
    vecs[5] = '{32'h0000_0005, 1'b0, 1'b0, 5'd9,  1'b1, 3'b100, 32'h0000_0200, 1'b1, 16'd3};
    vecs[6] = '{32'h0000_0000, 1'b1, 1'b1, 5'd31, 1'b1, 3'b101, 32'h0000_0300, 1'b0, 16'd3};
    vecs[7] = '{32'h0000_0007, 1'b0, 1'b0, 5'd1,  1'b0, 3'b010, 32'h0000_0400, 1'b1, 16'd4};
    vecs[8] = '{32'h0000_0007, 1'b0, 1'b0, 5'd2,  1'b0, 3'b001, 32'h0000_0500, 1'b0, 16'd4};
    vecs[9] = '{32'h0000_0001, 1'b0, 1'b0, 5'd4,  1'b1, 3'b011, 32'h0000_0600, 1'b0, 16'd4};

    rst = 1'b1; flush = 1'b0; out_ready = 1'b0;
    drive(32'h0, 1'b0, 1'b0, 5'd0, 1'b0, 3'b000, 32'h0);
    in_valid = 1'b0;
    tick(); tick();
    chk_cleared("reset");
    rst = 1'b0;

    for (int i = 0; i < 10; i++) begin
      drive(vecs[i].alu, vecs[i].z, vecs[i].m, vecs[i].rd, vecs[i].rw, vecs[i].bt, vecs[i].tg);
      out_ready = 1'b1;
      tick();
      in_valid = 1'b0;
      chk($sformatf("v%0d_valid", i), 64'(out_valid), 64'd1);
      chk($sformatf("v%0d_in_ready", i), 64'(in_ready), 64'd1);
      chk($sformatf("v%0d_result", i), 64'(out_result), 64'(vecs[i].alu));
      chk($sformatf("v%0d_flags", i), 64'({out_zero, out_minus}), 64'({vecs[i].z, vecs[i].m}));
      chk($sformatf("v%0d_rd", i), 64'({out_rd, out_reg_write}), 64'({vecs[i].rd, vecs[i].rw}));
      chk($sformatf("v%0d_taken", i), 64'(out_taken), 64'(vecs[i].e_taken));
      chk($sformatf("v%0d_target", i), 64'(out_target), 64'(vecs[i].tg));
      tick();
      chk($sformatf("v%0d_drained", i), 64'(out_valid), 64'd0);
      chk($sformatf("v%0d_count", i), 64'(taken_count), 64'(vecs[i].e_cnt));
    end
    exp_cnt = 4;

    // Skid: A to main, B to skid, C stalled until space frees up.
    out_ready = 1'b0;
    drive(32'hAAAA_0001, 1'b0, 1'b0, 5'd10, 1'b1, 3'b000, 32'h0);
    tick();
    chk("skid_a_main", 64'(out_result), 64'hAAAA_0001);
    chk("skid_a_ready", 64'(in_ready), 64'd1);
    drive(32'hBBBB_0002, 1'b0, 1'b0, 5'd11, 1'b1, 3'b000, 32'h0);
    tick();
    chk("skid_b_ready", 64'(in_ready), 64'd0);
    chk("skid_b_held", 64'({out_valid, out_result}), 64'({1'b1, 32'hAAAA_0001}));
    drive(32'hCCCC_0003, 1'b0, 1'b0, 5'd12, 1'b1, 3'b000, 32'h0);
    tick();
    chk("skid_c_ready", 64'(in_ready), 64'd0);
    chk("skid_c_held", 64'({out_rd, out_result}), 64'({5'd10, 32'hAAAA_0001}));
    out_ready = 1'b1;
    tick();
    chk("skid_deliv_b", 64'({out_valid, out_rd, out_result}), 64'({1'b1, 5'd11, 32'hBBBB_0002}));
    chk("skid_ready_back", 64'(in_ready), 64'd1);
    tick();
    in_valid = 1'b0;
    chk("skid_deliv_c", 64'({out_valid, out_rd, out_result}), 64'({1'b1, 5'd12, 32'hCCCC_0003}));
    tick();
    chk("skid_empty", 64'(out_valid), 64'd0);
    chk("skid_count", 64'(taken_count), 64'(exp_cnt));

    // Flush a full stage while a new entry is offered.
    out_ready = 1'b0;
    drive(32'h0, 1'b1, 1'b0, 5'd1, 1'b0, 3'b001, 32'h0000_0700);
    tick();
    drive(32'h0000_00EE, 1'b0, 1'b0, 5'd2, 1'b1, 3'b000, 32'h0);
    tick();
    chk("flush_full", 64'(in_ready), 64'd0);
    drive(32'h0000_00FF, 1'b1, 1'b0, 5'd3, 1'b1, 3'b001, 32'h0);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    in_valid = 1'b0;
    chk("flush_valid", 64'(out_valid), 64'd0);
    chk("flush_ready", 64'(in_ready), 64'd1);
    chk("flush_count", 64'(taken_count), 64'(exp_cnt));
    out_ready = 1'b1;
    tick(); tick();
    chk("flush_dropped", 64'(out_valid), 64'd0);
    chk("flush_count2", 64'(taken_count), 64'(exp_cnt));

    // Flush together with a deliver of a taken branch: still counted.
    out_ready = 1'b0;
    drive(32'h0, 1'b1, 1'b0, 5'd1, 1'b0, 3'b001, 32'h0000_0800);
    tick();
    in_valid = 1'b0;
    out_ready = 1'b1;
    flush = 1'b1;
    tick();
    flush = 1'b0;
    exp_cnt = exp_cnt + 1;
    chk("flushdlv_valid", 64'(out_valid), 64'd0);
    chk("flushdlv_count", 64'(taken_count), 64'(exp_cnt));

    // Stream taken branches at full rate up to 0xFFFF, then wrap.
    drive(32'h0, 1'b1, 1'b0, 5'd0, 1'b0, 3'b001, 32'h0000_0900);
    repeat (16'hFFFF - exp_cnt) tick();
    in_valid = 1'b0;
    tick();
    chk("cnt_max", 64'(taken_count), 64'hFFFF);
    drive(32'h0, 1'b1, 1'b0, 5'd0, 1'b0, 3'b001, 32'h0000_0900);
    tick();
    in_valid = 1'b0;
    tick();
    chk("cnt_wrap", 64'(taken_count), 64'h0000);

    // Reset with both buffers occupied and downstream stalled.
    out_ready = 1'b0;
    drive(32'h0000_0055, 1'b0, 1'b1, 5'd7, 1'b1, 3'b011, 32'h0000_0200);
    tick();
    drive(32'h0000_0066, 1'b0, 1'b1, 5'd8, 1'b1, 3'b011, 32'h0000_0300);
    tick();
    chk("rst_full", 64'({in_ready, out_valid}), 64'({1'b0, 1'b1}));
    rst = 1'b1;
    tick();
    rst = 1'b0;
    in_valid = 1'b0;
    chk_cleared("rst_active");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
